// File: rtl/vga_scan.sv
// Free-running VGA raster scanner: pixel-rate divider, x/y counters and
// registered sync/blanking decodes aligned with the counter values they describe.
module vga_scan #(
  parameter int unsigned CLK_DIV  = 4,
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33,
  parameter bit          SYNC_POL = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  output logic       pix_tick,
  output logic [9:0] addr_x,
  output logic [9:0] addr_y,
  output logic       hsync,
  output logic       vsync,
  output logic       video_on,
  output logic       frame_start,
  output logic       vblank_start
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_MAX  = DIV_W'(CLK_DIV - 1);
  localparam logic [9:0]       X_MAX    = 10'(H_TOTAL - 1);
  localparam logic [9:0]       Y_MAX    = 10'(V_TOTAL - 1);
  localparam logic [9:0]       X_VIS    = 10'(H_ACTIVE);
  localparam logic [9:0]       Y_VIS    = 10'(V_ACTIVE);
  localparam logic [9:0]       Y_VB_PRE = 10'(V_ACTIVE - 1);
  localparam logic [9:0]       HS_BEG   = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0]       HS_END   = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0]       VS_BEG   = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0]       VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC);

  logic [DIV_W-1:0] div, div_n;
  logic [9:0]       x_n, y_n;
  logic             line_end;

  // Next-state counters; decodes below are taken from these so each output
  // lines up with the address it describes in the same cycle.
  always_comb begin
    div_n    = (div == DIV_MAX) ? '0 : div + 1'b1;
    line_end = pix_tick && (addr_x == X_MAX);
    x_n      = addr_x;
    y_n      = addr_y;
    if (pix_tick) begin
      if (addr_x == X_MAX) begin
        x_n = '0;
        y_n = (addr_y == Y_MAX) ? '0 : addr_y + 10'd1;
      end else begin
        x_n = addr_x + 10'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div          <= '0;
      pix_tick     <= 1'b0;
      addr_x       <= '0;
      addr_y       <= '0;
      hsync        <= ~SYNC_POL;
      vsync        <= ~SYNC_POL;
      video_on     <= 1'b0;
      frame_start  <= 1'b0;
      vblank_start <= 1'b0;
    end else begin
      div          <= div_n;
      pix_tick     <= (div_n == DIV_MAX);
      addr_x       <= x_n;
      addr_y       <= y_n;
      hsync        <= (x_n >= HS_BEG && x_n < HS_END) ? SYNC_POL : ~SYNC_POL;
      vsync        <= (y_n >= VS_BEG && y_n < VS_END) ? SYNC_POL : ~SYNC_POL;
      video_on     <= (x_n < X_VIS) && (y_n < Y_VIS);
      frame_start  <= line_end && (addr_y == Y_MAX);
      vblank_start <= line_end && (addr_y == Y_VB_PRE);
    end
  end

endmodule
